// File: rtl/mem_lsu_pkg.sv
// ----------------------------------------------------------------------------
// mem_lsu_pkg
//   Shared types for the load/store unit.
//   - lsu_state_t : access sequencer states (IDLE, LO beat, HI beat, DONE)
//   - BEATS       : bus beats per datapath word
// ----------------------------------------------------------------------------
package mem_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam int BEATS = 2;

endpackage

// File: rtl/mem_lsu_if.sv
// ----------------------------------------------------------------------------
// mem_lsu_if
//   Byte-wide valid/ready memory bus between the LSU (master) and memory (slave).
//   Signals:
//     valid  master->slave  beat request valid
//     we     master->slave  1 = write beat, 0 = read beat
//     addr   master->slave  beat byte address (AW bits)
//     wdata  master->slave  write beat data (BW bits)
//     ready  slave->master  beat accepted / read data valid
//     rdata  slave->master  read beat data (BW bits)
// ----------------------------------------------------------------------------
interface mem_lsu_if #(
  parameter int AW = 16,
  parameter int BW = 8
);

  logic          valid;
  logic          we;
  logic [AW-1:0] addr;
  logic [BW-1:0] wdata;
  logic          ready;
  logic [BW-1:0] rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rdata
  );

endinterface

// File: rtl/mem_lsu.sv
// ----------------------------------------------------------------------------
// mem_lsu
//   Load/store unit between the 16-bit CPU datapath and an 8-bit memory bus.
//   Each word access is split into two little-endian byte beats (addr, addr+1).
//   Ports:
//     clk       in   system clock, rising edge
//     reset     in   synchronous active-low reset
//     ld_req    in   load requested by current instruction
//     st_req    in   store requested by current instruction
//     addr      in   byte address of the word (n bits)
//     wdata     in   store data (n bits)
//     rdata     out  load result, registered (n bits)
//     stall     out  hold PC/register file this cycle
//     misalign  out  one-cycle pulse when a request is rejected
//     bus       master side of mem_lsu_if
// ----------------------------------------------------------------------------
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int n  = 16,
  parameter int AW = 16,
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_req,
  input  logic          st_req,
  input  logic [n-1:0]  addr,
  input  logic [n-1:0]  wdata,
  output logic [n-1:0]  rdata,
  output logic          stall,
  output logic          misalign,
  mem_lsu_if.master     bus
);

  lsu_state_t    state_r;
  logic [BW-1:0] wdata_hi_r;  // high store byte, held until the HI beat
  logic          req_s;
  logic          reject_s;

  // Request decode: odd address or simultaneous load+store is rejected.
  always_comb begin
    req_s    = ld_req | st_req;
    reject_s = addr[0] | (ld_req & st_req);
    stall    = 1'b0;
    misalign = 1'b0;
    if (!reset) begin
      stall    = 1'b0;
      misalign = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          stall    = req_s & ~reject_s;
          misalign = req_s & reject_s;
        end
        LO:      stall = 1'b1;
        HI:      stall = 1'b1;
        DONE:    stall = 1'b0;
        default: stall = 1'b0;
      endcase
    end
  end

  // Access sequencer with registered bus outputs and load result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      bus.valid  <= 1'b0;
      bus.we     <= 1'b0;
      bus.addr   <= '0;
      bus.wdata  <= '0;
      wdata_hi_r <= '0;
      rdata      <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s && !reject_s) begin
            state_r    <= LO;
            bus.valid  <= 1'b1;
            bus.we     <= st_req;
            bus.addr   <= addr[AW-1:0];
            bus.wdata  <= wdata[BW-1:0];
            wdata_hi_r <= wdata[n-1:BW];
          end
        end
        LO: begin
          // Bus outputs hold still through any number of wait states.
          if (bus.ready) begin
            if (!bus.we) begin
              rdata[BW-1:0] <= bus.rdata;
            end
            bus.addr  <= bus.addr + AW'(1);
            bus.wdata <= wdata_hi_r;
            state_r   <= HI;
          end
        end
        HI: begin
          if (bus.ready) begin
            if (!bus.we) begin
              rdata[n-1:BW] <= bus.rdata;
            end
            bus.valid <= 1'b0;
            bus.we    <= 1'b0;
            state_r   <= DONE;
          end
        end
        DONE: begin
          // Retire cycle: new requests are not looked at until IDLE.
          state_r <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          bus.valid <= 1'b0;
          bus.we    <= 1'b0;
        end
      endcase
    end
  end

endmodule
